// File: rtl/cnn16_ctrl_pkg.sv
// Shared constants, state encoding and strobe bundle for the CNN16 control unit.
package cnn16_ctrl_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_MUL = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_LDV = 4'h7;
   localparam logic [3:0] OP_LDK = 4'h8;
   localparam logic [3:0] OP_OUT = 4'h9;
   localparam logic [3:0] OP_IN  = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [4:0] BUS_DR   = 5'd0;
   localparam logic [4:0] BUS_AC   = 5'd1;
   localparam logic [4:0] BUS_PC   = 5'd3;
   localparam logic [4:0] BUS_MEM  = 5'd4;
   localparam logic [4:0] BUS_VREG = 5'd7;
   localparam logic [4:0] BUS_KREG = 5'd8;
   localparam logic [4:0] BUS_INPR = 5'd11;
   localparam logic [4:0] BUS_IR   = 5'd14;

   localparam logic [3:0] ALU_ADD_DEF   = 4'h0;
   localparam logic [3:0] ALU_SUB_DEF   = 4'h1;
   localparam logic [3:0] ALU_MUL_DEF   = 4'h2;
   localparam logic [3:0] ALU_PASSB_DEF = 4'hF;
   localparam int         TIMEOUT_DEF   = 64;

   typedef enum logic [3:0] {
      FETCH0, FETCH1, DECODE, EXEC_RD, EXEC_ALU, EXEC_WR, EXEC_OUT, EXEC_IN, HALT
   } state_t;

   typedef struct packed {
      logic       ac_load, dr_load, tr_load, ir_load, vreg_load, kreg_load, greg_load;
      logic       oreg_load, inpr_load, outr_load, pc_load, ar_load, xreg_load, yreg_load;
      logic       pc_inc, ar_inc, mem_rd, mem_wr, halted, illegal_op;
      logic [3:0] alu_sel;
      logic [4:0] bus_sel;
   } ctrl_t;

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'hB) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/cnn16_ctrl_decode.sv
// Combinational map from FSM state, opcode, mem_ready and AC==0 to the strobe bundle.
module cnn16_ctrl_decode
   import cnn16_ctrl_pkg::*;
#(
   parameter logic [3:0] ALU_ADD   = ALU_ADD_DEF,
   parameter logic [3:0] ALU_SUB   = ALU_SUB_DEF,
   parameter logic [3:0] ALU_MUL   = ALU_MUL_DEF,
   parameter logic [3:0] ALU_PASSB = ALU_PASSB_DEF
) (
   input  state_t     state,
   input  logic [3:0] opcode,
   input  logic       mem_ready,
   input  logic       ac_zero,
   output ctrl_t      ctl
);

   always_comb begin
      ctl = '0;
      case (state)
         FETCH0: begin
            ctl.bus_sel = BUS_PC;
            ctl.ar_load = 1'b1;
         end
         FETCH1: begin
            ctl.mem_rd  = 1'b1;
            ctl.bus_sel = BUS_MEM;
            ctl.ir_load = mem_ready;
            ctl.pc_inc  = mem_ready;
         end
         DECODE: begin
            ctl.bus_sel    = BUS_IR;
            ctl.ar_load    = 1'b1;
            ctl.pc_load    = (opcode == OP_JMP) || ((opcode == OP_JZ) && ac_zero);
            ctl.illegal_op = is_illegal(opcode);
         end
         EXEC_RD: begin
            ctl.mem_rd    = 1'b1;
            ctl.bus_sel   = BUS_MEM;
            // LDV/LDK land the word directly in their register, skipping the ALU
            ctl.vreg_load = mem_ready && (opcode == OP_LDV);
            ctl.kreg_load = mem_ready && (opcode == OP_LDK);
            ctl.dr_load   = mem_ready && (opcode != OP_LDV) && (opcode != OP_LDK);
         end
         EXEC_ALU: begin
            ctl.ac_load = 1'b1;
            case (opcode)
               OP_ADD:  ctl.alu_sel = ALU_ADD;
               OP_SUB:  ctl.alu_sel = ALU_SUB;
               OP_MUL:  ctl.alu_sel = ALU_MUL;
               default: ctl.alu_sel = ALU_PASSB;
            endcase
         end
         EXEC_WR: begin
            ctl.bus_sel = BUS_AC;
            ctl.mem_wr  = 1'b1;
         end
         EXEC_OUT: begin
            ctl.bus_sel   = BUS_AC;
            ctl.outr_load = 1'b1;
         end
         EXEC_IN: begin
            ctl.bus_sel = BUS_INPR;
            ctl.dr_load = 1'b1;
         end
         HALT:    ctl.halted = 1'b1;
         default: ctl = '0;
      endcase
   end

endmodule

// File: rtl/cnn16_control_unit.sv
// CNN16 fetch/decode/execute sequencer. Define CNN16_CTRL_TIMEOUT_EN to add the
// memory-wait watchdog (sticky mem_timeout, forced HALT).
module cnn16_control_unit
   import cnn16_ctrl_pkg::*;
#(
   parameter logic [3:0] ALU_ADD   = ALU_ADD_DEF,
   parameter logic [3:0] ALU_SUB   = ALU_SUB_DEF,
   parameter logic [3:0] ALU_MUL   = ALU_MUL_DEF,
   parameter logic [3:0] ALU_PASSB = ALU_PASSB_DEF,
   parameter int         TIMEOUT   = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] IR_Value,
   input  logic [15:0] AC_Value,
   input  logic        mem_ready,
   input  logic        start,
   output logic        AC_Load,
   output logic        DR_Load,
   output logic        TR_Load,
   output logic        IR_Load,
   output logic        VREG_Load,
   output logic        KREG_Load,
   output logic        GREG_Load,
   output logic        OREG_Load,
   output logic        INPR_Load,
   output logic        OUTR_Load,
   output logic        PC_Load,
   output logic        AR_Load,
   output logic        XREG_Load,
   output logic        YREG_Load,
   output logic        PC_Inc,
   output logic        AR_Inc,
   output logic [3:0]  alu_sel,
   output logic [4:0]  bus_sel,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        halted,
   output logic        illegal_op,
   output logic [15:0] instr_count,
   output logic        mem_timeout
);

   state_t     state, state_nxt;
   ctrl_t      dec, ctl;
   logic [3:0] opcode;
   logic       done, to_hit;
   logic       addr_unused;

   assign opcode      = IR_Value[15:12];
   assign addr_unused = ^IR_Value[11:0];

   cnn16_ctrl_decode #(
      .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB), .ALU_MUL(ALU_MUL), .ALU_PASSB(ALU_PASSB)
   ) u_decode (
      .state(state), .opcode(opcode), .mem_ready(mem_ready),
      .ac_zero(AC_Value == 16'h0000), .ctl(dec)
   );

   // Reset must silence FETCH0's strobes too, so gate the whole bundle.
   assign ctl = rst ? '0 : dec;

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         FETCH0: state_nxt = FETCH1;
         FETCH1: if (mem_ready) state_nxt = DECODE;
         DECODE: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_MUL, OP_LDV, OP_LDK: state_nxt = EXEC_RD;
               OP_STA: state_nxt = EXEC_WR;
               OP_OUT: state_nxt = EXEC_OUT;
               OP_IN:  state_nxt = EXEC_IN;
               OP_HLT: begin
                  state_nxt = HALT;
                  done      = 1'b1;
               end
               default: begin
                  state_nxt = FETCH0;
                  done      = 1'b1;
               end
            endcase
         end
         EXEC_RD: begin
            if (mem_ready) begin
               if ((opcode == OP_LDV) || (opcode == OP_LDK)) begin
                  state_nxt = FETCH0;
                  done      = 1'b1;
               end else begin
                  state_nxt = EXEC_ALU;
               end
            end
         end
         EXEC_ALU, EXEC_OUT: begin
            state_nxt = FETCH0;
            done      = 1'b1;
         end
         EXEC_WR: begin
            if (mem_ready) begin
               state_nxt = FETCH0;
               done      = 1'b1;
            end
         end
         EXEC_IN: state_nxt = EXEC_ALU;
         HALT:    if (start) state_nxt = FETCH0;
         default: state_nxt = FETCH0;
      endcase
      if (to_hit) begin
         state_nxt = HALT;
         done      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH0;
         instr_count <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (done) instr_count <= instr_count + 16'h0001;
      end
   end

`ifdef CNN16_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;
   logic          waiting, to_flag;

   assign waiting = (state == FETCH1) || (state == EXEC_RD) || (state == EXEC_WR);
   assign to_hit  = waiting && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

   // Any state change is an entry into a fresh wait, so the count restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         to_flag  <= 1'b0;
      end else begin
         if (to_hit) to_flag <= 1'b1;
         if (state_nxt != state) wait_cnt <= '0;
         else if (waiting)       wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign mem_timeout = to_flag;
`else
   localparam int TIMEOUT_unused = TIMEOUT;
   assign to_hit      = 1'b0;
   assign mem_timeout = 1'b0;
`endif

   assign AC_Load    = ctl.ac_load;
   assign DR_Load    = ctl.dr_load;
   assign TR_Load    = ctl.tr_load;
   assign IR_Load    = ctl.ir_load;
   assign VREG_Load  = ctl.vreg_load;
   assign KREG_Load  = ctl.kreg_load;
   assign GREG_Load  = ctl.greg_load;
   assign OREG_Load  = ctl.oreg_load;
   assign INPR_Load  = ctl.inpr_load;
   assign OUTR_Load  = ctl.outr_load;
   assign PC_Load    = ctl.pc_load;
   assign AR_Load    = ctl.ar_load;
   assign XREG_Load  = ctl.xreg_load;
   assign YREG_Load  = ctl.yreg_load;
   assign PC_Inc     = ctl.pc_inc;
   assign AR_Inc     = ctl.ar_inc;
   assign alu_sel    = ctl.alu_sel;
   assign bus_sel    = ctl.bus_sel;
   assign mem_rd     = ctl.mem_rd;
   assign mem_wr     = ctl.mem_wr;
   assign halted     = ctl.halted;
   assign illegal_op = ctl.illegal_op;

endmodule

// File: tb/tb_cnn16_control_unit.sv
// Directed cycle-by-cycle bench for cnn16_control_unit: a per-cycle vector table
// plus hand sequences for memory waits, HALT/start, reset and the watchdog.
module tb_cnn16_control_unit;

   logic        clk, rst, mem_ready, start;
   logic [15:0] IR_Value, AC_Value;
   logic        AC_Load, DR_Load, TR_Load, IR_Load, VREG_Load, KREG_Load, GREG_Load;
   logic        OREG_Load, INPR_Load, OUTR_Load, PC_Load, AR_Load, XREG_Load, YREG_Load;
   logic        PC_Inc, AR_Inc, mem_rd, mem_wr, halted, illegal_op, mem_timeout;
   logic [3:0]  alu_sel;
   logic [4:0]  bus_sel;
   logic [15:0] instr_count;

   cnn16_control_unit dut (
      .clk(clk), .rst(rst), .IR_Value(IR_Value), .AC_Value(AC_Value),
      .mem_ready(mem_ready), .start(start),
      .AC_Load(AC_Load), .DR_Load(DR_Load), .TR_Load(TR_Load), .IR_Load(IR_Load),
      .VREG_Load(VREG_Load), .KREG_Load(KREG_Load), .GREG_Load(GREG_Load),
      .OREG_Load(OREG_Load), .INPR_Load(INPR_Load), .OUTR_Load(OUTR_Load),
      .PC_Load(PC_Load), .AR_Load(AR_Load), .XREG_Load(XREG_Load), .YREG_Load(YREG_Load),
      .PC_Inc(PC_Inc), .AR_Inc(AR_Inc), .alu_sel(alu_sel), .bus_sel(bus_sel),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal_op(illegal_op),
      .instr_count(instr_count), .mem_timeout(mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed strobe bits, packed as {AC,DR,IR,VREG,KREG,OUTR,PC_Load,AR,PC_Inc,rd,wr,halted,illegal}
   localparam logic [12:0] S_AC = 13'h1000, S_DR = 13'h0800, S_IR = 13'h0400, S_VR = 13'h0200;
   localparam logic [12:0] S_KR = 13'h0100, S_OU = 13'h0080, S_PC = 13'h0040, S_AR = 13'h0020;
   localparam logic [12:0] S_PI = 13'h0010, S_RD = 13'h0008, S_WR = 13'h0004, S_HL = 13'h0002;
   localparam logic [12:0] S_IL = 13'h0001, S_NONE = 13'h0000;
   localparam logic [4:0]  DC   = 5'h1F;   // bus_sel not checked on this cycle

   typedef struct {
      logic [15:0] ir, ac;
      logic        rdy, st;
      logic [12:0] sig;
      logic [4:0]  bus;
      logic [3:0]  alu;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0, n_fail = 0;
   logic exp_to = 1'b0;

   function automatic logic [12:0] sig_now();
      return {AC_Load, DR_Load, IR_Load, VREG_Load, KREG_Load, OUTR_Load, PC_Load,
              AR_Load, PC_Inc, mem_rd, mem_wr, halted, illegal_op};
   endfunction

   function automatic logic [15:0] unused_now();
      return {9'd0, TR_Load, GREG_Load, OREG_Load, XREG_Load, YREG_Load, AR_Inc, INPR_Load};
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle's inputs, compare the combinational outputs, advance a clock.
   task automatic step(input logic [15:0] ir, input logic [15:0] ac, input logic rdy,
                       input logic st, input logic [12:0] sig, input logic [4:0] bus,
                       input logic [3:0] alu, input logic [15:0] cnt, input string nm);
      IR_Value = ir; AC_Value = ac; mem_ready = rdy; start = st;
      #1;
      check({nm, " strobes"}, {3'd0, sig_now()}, {3'd0, sig});
      check({nm, " reserved"}, unused_now(), 16'h0);
      if (bus != DC) check({nm, " bus_sel"}, {11'd0, bus_sel}, {11'd0, bus});
      if (sig[12]) check({nm, " alu_sel"}, {12'd0, alu_sel}, {12'd0, alu});
      check({nm, " instr_count"}, instr_count, cnt);
      check({nm, " mem_timeout"}, {15'd0, mem_timeout}, {15'd0, exp_to});
      @(negedge clk);
   endtask

   task automatic chk_rst(input string nm);
      check({nm, " strobes"}, {3'd0, sig_now()}, 16'h0);
      check({nm, " reserved"}, unused_now(), 16'h0);
      check({nm, " bus_sel"}, {11'd0, bus_sel}, 16'h0);
      check({nm, " alu_sel"}, {12'd0, alu_sel}, 16'h0);
      check({nm, " instr_count"}, instr_count, 16'h0);
      check({nm, " mem_timeout"}, {15'd0, mem_timeout}, 16'h0);
   endtask

   task automatic v(input logic [15:0] ir, input logic [15:0] ac, input logic [12:0] sig,
                    input logic [4:0] bus, input logic [3:0] alu, input logic [15:0] cnt);
      vec_t r;
      r.ir = ir; r.ac = ac; r.rdy = 1'b1; r.st = 1'b0;
      r.sig = sig; r.bus = bus; r.alu = alu; r.cnt = cnt;
      tbl.push_back(r);
   endtask

   // FETCH0, FETCH1 (zero-wait) and the plain DECODE cycle
   task automatic fd(input logic [15:0] ir, input logic [15:0] ac, input logic [12:0] dsig,
                     input logic [15:0] cnt);
      v(ir, ac, S_AR, 5'd3, 4'h0, cnt);
      v(ir, ac, S_RD | S_IR | S_PI, 5'd4, 4'h0, cnt);
      v(ir, ac, S_AR | dsig, 5'd14, 4'h0, cnt);
   endtask

   initial begin
      rst = 1'b1; IR_Value = 16'h0; AC_Value = 16'h0; mem_ready = 1'b0; start = 1'b0;

      fd(16'h0010, 16'h0, S_NONE, 0);                       // LDA 0x010
      v(16'h0010, 16'h0, S_RD | S_DR, 5'd4, 4'h0, 0);
      v(16'h0010, 16'h0, S_AC, DC, 4'hF, 0);
      fd(16'h3000, 16'h0, S_NONE, 1);                       // SUB
      v(16'h3000, 16'h0, S_RD | S_DR, 5'd4, 4'h0, 1);
      v(16'h3000, 16'h0, S_AC, DC, 4'h1, 1);
      fd(16'h4000, 16'h0, S_NONE, 2);                       // MUL
      v(16'h4000, 16'h0, S_RD | S_DR, 5'd4, 4'h0, 2);
      v(16'h4000, 16'h0, S_AC, DC, 4'h2, 2);
      fd(16'h1000, 16'h0, S_NONE, 3);                       // STA
      v(16'h1000, 16'h0, S_WR, 5'd1, 4'h0, 3);
      fd(16'h6123, 16'h0000, S_PC, 4);                      // JZ taken
      fd(16'h6123, 16'h0005, S_NONE, 5);                    // JZ not taken
      fd(16'h5123, 16'h0005, S_PC, 6);                      // JMP
      fd(16'h7010, 16'h0, S_NONE, 7);                       // LDV
      v(16'h7010, 16'h0, S_RD | S_VR, 5'd4, 4'h0, 7);
      fd(16'h8010, 16'h0, S_NONE, 8);                       // LDK
      v(16'h8010, 16'h0, S_RD | S_KR, 5'd4, 4'h0, 8);
      fd(16'h9000, 16'h0, S_NONE, 9);                       // OUT
      v(16'h9000, 16'h0, S_OU, 5'd1, 4'h0, 9);
      fd(16'hA000, 16'h0, S_NONE, 10);                      // IN
      v(16'hA000, 16'h0, S_DR, 5'd11, 4'h0, 10);
      v(16'hA000, 16'h0, S_AC, DC, 4'hF, 10);
      fd(16'hC000, 16'h0, S_IL, 11);                        // illegal -> NOP
      fd(16'hF000, 16'h0, S_NONE, 12);                      // HLT

      @(negedge clk);
      chk_rst("reset");
      rst = 1'b0;

      foreach (tbl[i])
         step(tbl[i].ir, tbl[i].ac, tbl[i].rdy, tbl[i].st, tbl[i].sig, tbl[i].bus,
              tbl[i].alu, tbl[i].cnt, $sformatf("vec%0d", i));

      // HALT: start low for 10 cycles, mem_ready toggling has no effect
      for (int k = 0; k < 10; k++)
         step(16'hF000, 16'h0, k[0], 1'b0, S_HL, DC, 4'h0, 13, $sformatf("halt%0d", k));
      step(16'hF000, 16'h0, 1'b1, 1'b1, S_HL, DC, 4'h0, 13, "halt_start");

      // ADD with three wait cycles in EXEC_RD: 8 cycles total
      step(16'h2000, 16'h0, 1'b1, 1'b0, S_AR, 5'd3, 4'h0, 13, "add_f0");
      step(16'h2000, 16'h0, 1'b1, 1'b0, S_RD | S_IR | S_PI, 5'd4, 4'h0, 13, "add_f1");
      step(16'h2000, 16'h0, 1'b1, 1'b0, S_AR, 5'd14, 4'h0, 13, "add_dec");
      for (int k = 0; k < 3; k++)
         step(16'h2000, 16'h0, 1'b0, 1'b0, S_RD, 5'd4, 4'h0, 13, $sformatf("add_wait%0d", k));
      step(16'h2000, 16'h0, 1'b1, 1'b0, S_RD | S_DR, 5'd4, 4'h0, 13, "add_rd");
      step(16'h2000, 16'h0, 1'b1, 1'b0, S_AC, DC, 4'h0, 13, "add_alu");

      // STA with waits in FETCH1 and EXEC_WR; start held high must be ignored
      step(16'h1000, 16'h0, 1'b1, 1'b1, S_AR, 5'd3, 4'h0, 14, "sta_f0");
      step(16'h1000, 16'h0, 1'b0, 1'b1, S_RD, 5'd4, 4'h0, 14, "sta_f1w");
      step(16'h1000, 16'h0, 1'b1, 1'b1, S_RD | S_IR | S_PI, 5'd4, 4'h0, 14, "sta_f1");
      step(16'h1000, 16'h0, 1'b1, 1'b1, S_AR, 5'd14, 4'h0, 14, "sta_dec");
      step(16'h1000, 16'h0, 1'b0, 1'b1, S_WR, 5'd1, 4'h0, 14, "sta_wait0");
      step(16'h1000, 16'h0, 1'b0, 1'b1, S_WR, 5'd1, 4'h0, 14, "sta_wait1");
      step(16'h1000, 16'h0, 1'b1, 1'b1, S_WR, 5'd1, 4'h0, 14, "sta_wr");
      step(16'h5000, 16'h0, 1'b0, 1'b0, S_AR, 5'd3, 4'h0, 15, "post_f0");

`ifdef CNN16_CTRL_TIMEOUT_EN
      for (int k = 0; k < 64; k++)
         step(16'h5000, 16'h0, 1'b0, 1'b0, S_RD, 5'd4, 4'h0, 15, $sformatf("to_wait%0d", k));
      exp_to = 1'b1;
      step(16'h5000, 16'h0, 1'b0, 1'b0, S_HL, DC, 4'h0, 15, "to_halt");
      step(16'h5000, 16'h0, 1'b1, 1'b0, S_HL, DC, 4'h0, 15, "to_sticky");
`endif

      // Reset from wherever the FSM is, then reset again in the middle of a FETCH1 wait
      rst = 1'b1;
      #1;
      chk_rst("rst_a");
      exp_to = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(16'h5123, 16'h0, 1'b0, 1'b0, S_AR, 5'd3, 4'h0, 0, "rst_f0");
      IR_Value = 16'h5123; mem_ready = 1'b0;
      #1;
      check("mid_f1 mem_rd", {15'd0, mem_rd}, 16'h1);
      rst = 1'b1;
      #1;
      chk_rst("rst_mid");
      @(negedge clk);
      chk_rst("rst_held");
      rst = 1'b0;
      step(16'h5123, 16'h0, 1'b1, 1'b0, S_AR, 5'd3, 4'h0, 0, "re_f0");
      step(16'h5123, 16'h0, 1'b1, 1'b0, S_RD | S_IR | S_PI, 5'd4, 4'h0, 0, "re_f1");
      step(16'h5123, 16'h0, 1'b1, 1'b0, S_AR | S_PC, 5'd14, 4'h0, 0, "re_jmp");
      step(16'h5123, 16'h0, 1'b1, 1'b0, S_AR, 5'd3, 4'h0, 1, "re_next");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn16_control_unit.md
Name: cnn16_control_unit

Overview:
- Multi-cycle sequencer for the CNN16 datapath: fetch/decode/execute FSM driving every register load/increment strobe, `bus_sel`, `alu_sel` and the memory read/write handshake.
- Sits beside the datapath. It consumes `IR_Value` and `AC_Value`. It exchanges `mem_rd`, `mem_wr` and `mem_ready` with the memory wrapper.

Parameters:
- ALU_ADD, 4'h0, `alu_sel` code for AC+DR
- ALU_SUB, 4'h1, `alu_sel` code for AC-DR
- ALU_MUL, 4'h2, `alu_sel` code for AC*DR
- ALU_PASSB, 4'hF, `alu_sel` code for result=DR
- TIMEOUT, 64, memory wait limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- IR_Value  in  16  instruction register; [15:12] opcode, [11:0] address
- AC_Value  in  16  accumulator, used for the JZ test
- mem_ready  in  1  memory completes the current rd/wr this cycle
- start  in  1  leave HALT
- AC_Load, DR_Load, TR_Load, IR_Load, VREG_Load, KREG_Load, GREG_Load, OREG_Load, INPR_Load, OUTR_Load, PC_Load, AR_Load, XREG_Load, YREG_Load  out  1 each  datapath load strobes
- PC_Inc, AR_Inc  out  1 each  increment strobes
- alu_sel  out  4  ALU operation
- bus_sel  out  5  bus source: DR=0, AC=1, PC=3, MEM=4, VREG=7, KREG=8, INPR=11, IR=14
- mem_rd, mem_wr  out  1 each  memory request, held until mem_ready
- halted  out  1  FSM in HALT
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- instr_count  out  16  completed-instruction counter
- mem_timeout  out  1  sticky watchdog flag (tied 0 without the feature)

Behaviour:
- Reset is asynchronous and active-high. It sets state=FETCH0, instr_count=0, mem_timeout=0.
- While rst=1, all strobes are 0, bus_sel=0 and alu_sel=0. halted=0 and illegal_op=0.
- All outputs decode combinationally from the state. Some are additionally gated by mem_ready or by opcode.
- States and actions:
  - FETCH0: bus_sel=PC, AR_Load. Goes to FETCH1.
  - FETCH1: mem_rd, bus_sel=MEM. When mem_ready: IR_Load and PC_Inc, go to DECODE. Otherwise stay.
  - DECODE: bus_sel=IR, AR_Load (AR<=IR[11:0]). Then branches by opcode.
- Opcode actions:
  - 0 LDA, 2 ADD, 3 SUB, 4 MUL -> EXEC_RD.
    - EXEC_RD: mem_rd, bus_sel=MEM. When mem_ready: DR_Load, go to EXEC_ALU.
    - EXEC_ALU: AC_Load with alu_sel = PASSB (LDA), ADD, SUB or MUL. Then FETCH0.
  - 1 STA -> EXEC_WR: bus_sel=AC, mem_wr. When mem_ready, go to FETCH0.
  - 5 JMP: in DECODE also PC_Load. Then FETCH0.
  - 6 JZ: in DECODE also PC_Load only if AC_Value==16'h0000. Then FETCH0.
  - 7 LDV, 8 LDK -> EXEC_RD. When mem_ready: VREG_Load / KREG_Load instead of DR_Load, then FETCH0.
  - 9 OUT -> EXEC_OUT: bus_sel=AC, OUTR_Load. Then FETCH0.
  - A IN -> EXEC_IN: bus_sel=INPR, DR_Load. Then EXEC_ALU with PASSB.
  - F HLT -> HALT.
  - B-E illegal: illegal_op pulses in DECODE, treated as NOP, then FETCH0.
- HALT: halted=1, no strobes. start=1 goes to FETCH0. start is ignored in every other state.
- Latency with zero-wait memory (mem_ready already high):
  - JMP, JZ, NOP, HLT: 3 cycles
  - STA, OUT: 4 cycles
  - LDA, ADD, SUB, MUL, IN: 5 cycles
  - LDV, LDK: 4 cycles
  - Each mem_ready-low cycle adds 1.
- instr_count increments by 1 on the cycle an instruction's final state transitions out, including HLT and NOP. It wraps 16'hFFFF->0.
- mem_ready is ignored outside FETCH1, EXEC_RD and EXEC_WR.
- mem_rd and mem_wr are never asserted together.
- rst during a memory wait: requests drop immediately and the FSM restarts at FETCH0.
- Unused strobes (TR, GREG, OREG, XREG, YREG, AR_Inc) are held 0. They are reserved for later opcodes.

Optional Feature:
- Macro CNN16_CTRL_TIMEOUT_EN.
- When defined: a wait counter runs in FETCH1, EXEC_RD and EXEC_WR.
  - It clears on entry to any of these states.
  - After TIMEOUT consecutive cycles without mem_ready: the request drops, mem_timeout sets (sticky until rst), the FSM goes to HALT, and instr_count is not incremented.
- When undefined: the counter is absent, waits are unbounded, and mem_timeout is constant 0.

Decomposition:
- Package cnn16_ctrl_pkg holds:
  - opcode constants
  - bus_sel source codes
  - default ALU codes
  - state enum: FETCH0, FETCH1, DECODE, EXEC_RD, EXEC_ALU, EXEC_WR, EXEC_OUT, EXEC_IN, HALT
- One sub-module, cnn16_ctrl_decode: a combinational map from state, opcode, mem_ready and AC-zero to the strobe vector. The FSM and counters stay in the top.

Test Plan:
- LDA 0x010 (IR=16'h0010), mem_ready held 1 -> AR_Load in FETCH0 and DECODE; DR_Load, then AC_Load with alu_sel=4'hF; 5 cycles; instr_count 0->1.
- ADD with mem_ready low for 3 cycles in EXEC_RD -> mem_rd held 4 cycles; AC_Load exactly once with alu_sel=4'h0; total 8 cycles.
- JZ 0x123 with AC_Value=0, then again with AC_Value=16'h0005 -> PC_Load in DECODE for the first only; bus_sel=14 both times; 3 cycles each.
- STA: mem_wr with bus_sel=1 until mem_ready; mem_rd stays 0 throughout.
- HLT, then start pulse after 10 cycles -> halted=1 and no strobes while halted; FETCH0 on the cycle after start; IR=16'hC000 pulses illegal_op once.
- rst asserted mid-FETCH1 -> mem_rd=0 immediately; instr_count=0. With CNN16_CTRL_TIMEOUT_EN and TIMEOUT=64, mem_ready stuck low -> mem_timeout=1 and HALT after 64 wait cycles.
